product_bank_ctrl: RTL
======================

# product_bank_ctrl

Sequencing controller for the `register_product` bank, which holds `DIM_C x DIM_A` accumulator registers with a per-column write enable. Each accumulated `DIM_C`-wide vector from the adder trees arrives over a valid/ready handshake, and the block writes it into the next column by driving a one-hot `enable`. Once the configured number of columns is filled, it presents the bank as a full tile to the downstream consumer and repeats for a configured number of tiles. It handles control only; data flows directly from the adder trees into the bank.

## Interface
- `DIM_A`, default `` `DIM_A ``: number of bank columns, ≥ 2.
- `TILE_W`, default 16: width of the tile counter.
- `COL_W`, default `$clog2(DIM_A+1)`: width of the column-count fields.

- `clk`  in  1  clock; one clock domain only.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse; sampled only in IDLE.
- `cfg_cols`  in  COL_W  active columns per tile; latched on `start`.
- `cfg_tiles`  in  TILE_W  tiles in the job; latched on `start`.
- `abort`  in  1  synchronous; cancels the job from any state.
- `in_valid`  in  1  upstream vector is valid.
- `in_ready`  out  1  controller accepts a vector.
- `enable`  out  DIM_A  one-hot column write strobe to the bank.
- `out_valid`  out  1  bank holds a complete tile.
- `out_ready`  in  1  downstream has consumed the tile.
- `out_cols`  out  COL_W  number of valid columns in the tile (latched `cfg_cols`).
- `busy`  out  1  the state is not IDLE.
- `done`  out  1  single-cycle pulse at job completion.
- `cfg_err`  out  1  single-cycle pulse when `start` carries an illegal config.

## Operation
- States: IDLE, FILL, FULL. Registers: `col` (COL_W), `tiles_left` (TILE_W), `cols_q`.
- **IDLE**
  - `start` with `1 ≤ cfg_cols ≤ DIM_A` and `cfg_tiles ≠ 0`: latch both values, set `col=0`, move to FILL.
  - `start` with an illegal config: `cfg_err` pulses the next cycle and the state stays IDLE.
- **FILL**
  - `in_ready=1`.
  - `enable = (in_valid) ? (1 << col) : 0`. This is combinational, so the bank captures `in` on the same edge as the handshake.
  - On a handshake with `col < cols_q-1`: `col++`.
  - On a handshake with `col == cols_q-1`: `col=0`, move to FULL.
- **FULL**
  - `in_ready=0`, `enable=0`, `out_valid=1`, and the bank contents are stable.
  - On `out_ready`:
    - If `tiles_left > 1`: `tiles_left--`, move to FILL.
    - Otherwise: move to IDLE and pulse `done`.
- `enable` is never non-zero outside FILL and is never multi-hot. Columns at or above `cols_q` are never written.
- `abort` takes priority over every other input.
  - Next state is IDLE, and `col`/`tiles_left` are cleared.
  - `done` does not pulse.
  - If `abort` and `in_valid` coincide in FILL, `enable` is forced to 0 that cycle.
- `start` outside IDLE is ignored, with no error.
- When `start` and `abort` coincide in IDLE, `abort` wins and the job does not start.
- `out_valid` stays high until `out_ready`, and `out_cols` stays stable while `out_valid=1`.

## Timing
- Reset values: state IDLE; `in_ready`, `enable`, `out_valid`, `busy`, `done`, `cfg_err` all 0; `out_cols` 0.
- `start` in cycle t: `busy=1` and `in_ready=1` from cycle t+1.
- A column written at edge t is visible on the bank output from t+1.
- Last-column handshake at edge t: `out_valid=1` from t+1. The bank output is complete in that same cycle.
- Final `out_ready` handshake at edge t: `done=1` during cycle t+1 only, alongside `busy=0`.
- Next-tile handshake at edge t: `in_ready=1` from t+1. There is a one-cycle bubble per tile and no overlap, so the bank is never overwritten while full.
- Throughput in FILL is one column per cycle when `in_valid` is held high.

## Structure
- Shared package `tlut_ctrl_pkg`:
  - state enum `bank_state_e {IDLE, FILL, FULL}`;
  - `COL_W` derived from `` `DIM_A ``.
- The block is a single module with no sub-modules.
- The integration wrapper instantiates `product_bank_ctrl` beside the bank and wires `enable` straight to the bank's `enable`.

## Test plan
Scenarios 1–3 and 5 use `DIM_A=4`; scenario 4 uses `DIM_A=8`.
1. Reset mid-FILL: reset after 2 columns are written → all outputs return to 0 asynchronously. After release, the state is IDLE and `in_ready=0`.
2. Basic job: `cfg_cols=4`, `cfg_tiles=1`, `in_valid` held high → `enable` goes 0001, 0010, 0100, 1000 on consecutive cycles. `out_valid` rises the next cycle with `out_cols=4`. `out_ready` → `done` pulses one cycle later.
3. Partial tiles with stalls: `cfg_cols=3`, `cfg_tiles=2`, `in_valid` toggling and `out_ready` delayed 5 cycles →
   - `enable[3]` never asserts;
   - `in_ready=0` while `out_valid`;
   - exactly 6 enable pulses before `done`.
4. Illegal config: `start` with `cfg_cols=0`, then with `cfg_cols=9`, then with `cfg_tiles=0` → `cfg_err` pulses each time, `busy` stays 0, and `enable` stays 0.
5. Abort and ignored start:
   - `abort` in FILL together with `in_valid` → `enable=0` that cycle, IDLE next cycle, no `done`;
   - `start` while `busy` is ignored;
   - `start` and `abort` together in IDLE leaves the block in IDLE.

Source files
------------

// File: rtl/product_bank_ctrl_pkg.sv
// Shared control types for the tile-LUT datapath controllers.
// DIM_A falls back to 4 when the build does not define it.
`ifndef DIM_A
`define DIM_A 4
`endif

package tlut_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } bank_state_e;

    localparam int COL_W = $clog2(`DIM_A + 1);

endpackage

// File: rtl/product_bank_ctrl_if.sv
// Control/handshake bundle between the product bank controller and its job/stream peers.
`ifndef DIM_A
`define DIM_A 4
`endif

interface product_bank_ctrl_if #(
    parameter int DIM_A  = `DIM_A,
    parameter int TILE_W = 16,
    parameter int COL_W  = $clog2(DIM_A + 1)
);

    logic              start;
    logic [COL_W-1:0]  cfg_cols;
    logic [TILE_W-1:0] cfg_tiles;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [DIM_A-1:0]  enable;
    logic              out_valid;
    logic              out_ready;
    logic [COL_W-1:0]  out_cols;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, cfg_cols, cfg_tiles, abort, in_valid, out_ready,
        input  in_ready, enable, out_valid, out_cols, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_cols, cfg_tiles, abort, in_valid, out_ready,
        output in_ready, enable, out_valid, out_cols, busy, done, cfg_err
    );

endinterface

// File: rtl/product_bank_ctrl.sv
// Column sequencer for the register_product bank: steers each accumulated vector into the
// next column via a one-hot write strobe and hands the bank off as a tile once it is full.
`ifndef DIM_A
`define DIM_A 4
`endif

module product_bank_ctrl #(
    parameter int DIM_A  = `DIM_A,
    parameter int TILE_W = 16,
    parameter int COL_W  = $clog2(DIM_A + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    product_bank_ctrl_if.slave bus
);

    import tlut_ctrl_pkg::*;

    localparam logic [COL_W-1:0]  MAX_COLS = COL_W'(DIM_A);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

    bank_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  cols_q, cols_d;
    logic [TILE_W-1:0] tiles_left_q, tiles_left_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_legal;
    logic              last_col;
    logic              write_col;

    assign cfg_legal = (bus.cfg_cols != '0) && (bus.cfg_cols <= MAX_COLS) &&
                       (bus.cfg_tiles != '0);
    assign last_col  = ((col_q + COL_ONE) == cols_q);
    // Abort masks the strobe so a cancelled job never lands a partial write in the bank.
    assign write_col = (state_q == FILL) && bus.in_valid && !bus.abort;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cols_d       = cols_q;
        tiles_left_d = tiles_left_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;

        if (bus.abort) begin
            state_d      = IDLE;
            col_d        = '0;
            tiles_left_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_legal) begin
                            cols_d       = bus.cfg_cols;
                            tiles_left_d = bus.cfg_tiles;
                            col_d        = '0;
                            state_d      = FILL;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        if (last_col) begin
                            col_d   = '0;
                            state_d = FULL;
                        end else begin
                            col_d = col_q + COL_ONE;
                        end
                    end
                end
                FULL: begin
                    // Leaving FULL always passes through FILL's first cycle, so a
                    // following tile can never overwrite the one being consumed.
                    if (bus.out_ready) begin
                        if (tiles_left_q > TILE_ONE) begin
                            tiles_left_d = tiles_left_q - TILE_ONE;
                            state_d      = FILL;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            cols_q       <= '0;
            tiles_left_q <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cols_q       <= cols_d;
            tiles_left_q <= tiles_left_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.enable    = write_col ? (DIM_A'(1) << col_q) : '0;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_cols  = cols_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule
